// File: rtl/cache_coh_ctrl.sv
// Single-core MSI coherence controller: 4-line direct-mapped directory, miss FSM and bus snoop port.
// Optional saturating miss counter enabled by defining COH_MISS_CNT_EN.
module cache_coh_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [4:0] cpu_addr,
    output logic       stall,
    output logic       read_miss,
    output logic       write_miss,
    output logic [1:0] write_miss_state,
    output logic [4:0] tag_in,
    input  logic       grant,
    input  logic [4:0] tag_out,
    input  logic       search,
    output logic       search_found,
    input  logic       invalidate_tag,
    output logic       fill_done,
    output logic [7:0] miss_count
);

    localparam logic [1:0] ST_M = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_I = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, XFER, FILL} state_t;

    state_t     r_state;
    logic [2:0] r_tag [4];
    logic [1:0] r_st  [4];
    logic [4:0] r_addr;
    logic       r_is_rd;
    logic [1:0] r_cnt;
    logic       r_found;

    logic       w_cpu_match;
    logic       w_rd_hit;
    logic       w_wr_hit;
    logic       w_miss;
    logic       w_snp_hit;
    logic       w_pend_match;
    logic       w_busy;

    assign w_cpu_match  = (r_tag[cpu_addr[1:0]] == cpu_addr[4:2]);
    assign w_rd_hit     = w_cpu_match && (r_st[cpu_addr[1:0]] != ST_I);
    assign w_wr_hit     = w_cpu_match && (r_st[cpu_addr[1:0]] == ST_M);
    assign w_miss       = cpu_rd ? !w_rd_hit : (cpu_wr && !w_wr_hit);
    assign w_snp_hit    = (r_tag[tag_out[1:0]] == tag_out[4:2]) && (r_st[tag_out[1:0]] != ST_I);
    assign w_pend_match = (r_tag[r_addr[1:0]] == r_addr[4:2]);
    assign w_busy       = (r_state == REQ) || (r_state == XFER);

    // Stall rises combinationally on the miss cycle; request lines only decode registered state.
    assign stall            = ((r_state == IDLE) && w_miss) || w_busy;
    assign read_miss        = w_busy && r_is_rd;
    assign write_miss       = w_busy && !r_is_rd;
    assign tag_in           = r_addr;
    assign write_miss_state = w_pend_match ? r_st[r_addr[1:0]] : ST_I;
    assign search_found     = r_found;
    assign fill_done        = (r_state == FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_is_rd <= 1'b0;
            r_cnt   <= '0;
            r_found <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i] <= '0;
                r_st[i]  <= ST_I;
            end
        end else begin
            r_found <= search && w_snp_hit;
            if (search && w_snp_hit && (r_st[tag_out[1:0]] == ST_M))
                r_st[tag_out[1:0]] <= ST_S;
            if (invalidate_tag && w_snp_hit)
                r_st[tag_out[1:0]] <= ST_I;

            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_addr  <= cpu_addr;
                        r_is_rd <= cpu_rd;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (grant) begin
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (!grant) begin
                        r_cnt   <= '0;
                        r_state <= REQ;
                    end else if (r_cnt == 2'd3) begin
                        r_cnt   <= '0;
                        r_state <= FILL;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                FILL: begin
                    // Written after the snoop updates so a same-line invalidate loses to the fill.
                    r_tag[r_addr[1:0]] <= r_addr[4:2];
                    r_st[r_addr[1:0]]  <= r_is_rd ? ST_S : ST_M;
                    r_state            <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef COH_MISS_CNT_EN
    logic [7:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_miss_cnt <= '0;
        else if ((r_state == IDLE) && w_miss && (r_miss_cnt != 8'hFF))
            r_miss_cnt <= r_miss_cnt + 8'd1;
    end

    assign miss_count = r_miss_cnt;
`else
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_coh_ctrl.sv
// Directed self-checking bench for cache_coh_ctrl; drives and samples on the falling clock edge.
// Expected miss_count follows COH_MISS_CNT_EN.
module tb_cache_coh_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_rd, cpu_wr;
    logic [4:0] cpu_addr;
    logic       stall, read_miss, write_miss;
    logic [1:0] write_miss_state;
    logic [4:0] tag_in;
    logic       grant;
    logic [4:0] tag_out;
    logic       search, search_found, invalidate_tag, fill_done;
    logic [7:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_coh_ctrl dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .stall(stall), .read_miss(read_miss), .write_miss(write_miss),
        .write_miss_state(write_miss_state), .tag_in(tag_in), .grant(grant),
        .tag_out(tag_out), .search(search), .search_found(search_found),
        .invalidate_tag(invalidate_tag), .fill_done(fill_done), .miss_count(miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Counts falling edges until fill_done; the core drops its request on that edge.
    task automatic wait_fill(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!fill_done && n < 30);
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_stall_at_fill"}, stall, 1'b0);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        grant  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; grant = 0;
        tag_out = '0; search = 0; invalidate_tag = 0;
        step(); step();

        chk("rst_stall", stall, 0);
        chk("rst_read_miss", read_miss, 0);
        chk("rst_write_miss", write_miss, 0);
        chk("rst_search_found", search_found, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_wms", write_miss_state, 2'b10);
        chk("rst_tag_in", tag_in, 0);

        rst = 1'b0;
        step();

        // Read miss to 0D, grant from the first REQ cycle
        cpu_rd = 1; cpu_addr = 5'h0D;
        #1 chk("rd_stall_comb", stall, 1);
        chk("rd_no_req_yet", read_miss, 0);
        step();
        chk("rd_read_miss", read_miss, 1);
        chk("rd_write_miss", write_miss, 0);
        chk("rd_tag_in", tag_in, 5'h0D);
        chk("rd_wms", write_miss_state, 2'b10);
        grant = 1;
        wait_fill("rd", 5);
        step();
        chk("rd_line_S", write_miss_state, 2'b01);
        chk("rd_fill_pulse", fill_done, 0);
`ifdef COH_MISS_CNT_EN
        chk("rd_miss_count", miss_count, 1);
`else
        chk("rd_miss_count", miss_count, 0);
`endif

        // Repeat read hits
        cpu_rd = 1; cpu_addr = 5'h0D;
        #1 chk("hit_stall", stall, 0);
        step();
        chk("hit_no_read_miss", read_miss, 0);
        chk("hit_stall_next", stall, 0);
        cpu_rd = 0;
        step();

        // Write upgrade from S
        cpu_wr = 1; cpu_addr = 5'h0D;
        #1 chk("wr_stall_comb", stall, 1);
        step();
        chk("wr_write_miss", write_miss, 1);
        chk("wr_read_miss", read_miss, 0);
        chk("wr_wms_S", write_miss_state, 2'b01);
        grant = 1;
        wait_fill("wr", 5);
        step();
        chk("wr_line_M", write_miss_state, 2'b00);

        // Snoop search on M line downgrades to S
        search = 1; tag_out = 5'h0D;
        step();
        chk("snp_found", search_found, 1);
        chk("snp_line_S", write_miss_state, 2'b01);
        search = 0;
        step();
        chk("snp_found_clear", search_found, 0);
        search = 1; tag_out = 5'h11;
        step();
        chk("snp_miss_tag", search_found, 0);
        search = 0;

        // Fill 0E as S, then write miss with invalidate during REQ
        cpu_rd = 1; cpu_addr = 5'h0E;
        step();
        grant = 1;
        wait_fill("rd0e", 5);
        step();
        chk("rd0e_line_S", write_miss_state, 2'b01);
        cpu_wr = 1; cpu_addr = 5'h0E;
        step();
        chk("inv_write_miss", write_miss, 1);
        chk("inv_wms_before", write_miss_state, 2'b01);
        invalidate_tag = 1; tag_out = 5'h0E;
        step();
        invalidate_tag = 0;
        chk("inv_write_miss_held", write_miss, 1);
        chk("inv_wms_after", write_miss_state, 2'b10);
        step();
        chk("inv_still_held", write_miss, 1);
        chk("inv_still_stall", stall, 1);
        grant = 1;
        wait_fill("inv", 5);
        step();
        chk("inv_line_M", write_miss_state, 2'b00);

        // Grant dropped in XFER cycle 2 restarts the transfer count
        cpu_rd = 1; cpu_addr = 5'h11;
        step();
        grant = 1;
        step();
        step();
        grant = 0;
        step();
        chk("gd_read_miss", read_miss, 1);
        chk("gd_stall", stall, 1);
        chk("gd_no_fill", fill_done, 0);
        grant = 1;
        wait_fill("gd", 5);
        step();
        chk("gd_line_S", write_miss_state, 2'b01);

        // 300 conflicting read misses on index 0
        for (int k = 0; k < 300; k++) begin
            cpu_rd = 1; cpu_addr = (k % 2 == 0) ? 5'h00 : 5'h04;
            grant = 1;
            begin
                int n;
                n = 0;
                do begin step(); n++; end while (!fill_done && n < 30);
                if (n >= 30) chk("bulk_timeout", n, 0);
            end
            cpu_rd = 0; grant = 0;
            step();
        end
`ifdef COH_MISS_CNT_EN
        chk("bulk_miss_count", miss_count, 255);
`else
        chk("bulk_miss_count", miss_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_coh_ctrl.md
CACHE_COH_CTRL -- requirements
Module: cache_coh_ctrl

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have these ports (name  direction  width  meaning):
  clk  in  1  rising-edge clock
  rst  in  1  async active-high reset
  cpu_rd  in  1  core load request, held until stall low
  cpu_wr  in  1  core store request, held until stall low; cpu_rd has priority if both set
  cpu_addr  in  5  core address; index = [1:0], tag = [4:2]
  stall  out  1  core must hold request
  read_miss  out  1  read-miss request to bus arbiter
  write_miss  out  1  write-miss request to bus arbiter
  write_miss_state  out  2  local state of target line: 00 MODIFIED, 01 SHARED, 10 INVALID
  tag_in  out  5  miss address presented to bus
  grant  in  1  bus grant to this core
  tag_out  in  5  snoop address from bus
  search  in  1  bus asks whether tag_out is held valid
  search_found  out  1  registered snoop-hit answer
  invalidate_tag  in  1  bus orders invalidation of tag_out
  fill_done  out  1  one-cycle pulse when a miss completes
  miss_count  out  8  saturating miss counter (see Configuration)

Function
REQ-003 SHALL hold a 4-line direct-mapped directory; each line = 3-bit tag + 2-bit MSI state (encodings as in REQ-002; 11 is never stored).
REQ-004 SHALL treat a read as a hit when the line tag matches and state is M or S; stall stays low and the directory is unchanged.
REQ-005 SHALL treat a write as a hit only when tag matches and state is M; stall stays low.
REQ-006 SHALL implement the FSM IDLE -> REQ -> XFER -> FILL -> IDLE.
REQ-007 IDLE: on a read or write miss, go to REQ and assert stall combinationally in the same cycle.
REQ-008 REQ: assert exactly one of read_miss or write_miss, hold tag_in = cpu_addr and write_miss_state = current local state of the indexed line (INVALID on tag mismatch); stay until grant = 1.
REQ-009 XFER: keep the request asserted and count 4 cycles with grant high using a 2-bit counter; after the 4th cycle, go to FILL.
REQ-010 If grant drops during XFER, SHALL clear the counter and return to REQ.
REQ-011 FILL: write tag; state = S for a read miss, M for a write miss; pulse fill_done; deassert stall and the request; return to IDLE.
REQ-012 Miss latency SHALL be 6 cycles from request to stall low when grant is given in the first REQ cycle.
REQ-013 search: search_found SHALL be 1 the cycle after search when the line indexed by tag_out[1:0] has tag = tag_out[4:2] and state is M or S; otherwise 0.
REQ-014 A snoop hit on an M line SHALL downgrade that line to S in the same registered update.
REQ-015 invalidate_tag with a matching valid line SHALL set that line to INVALID on the next edge.
REQ-016 Snoops SHALL be serviced in every FSM state, including REQ and XFER.
REQ-017 An invalidate that hits the pending line during REQ SHALL update write_miss_state to INVALID while the request is still held.
REQ-018 If FILL and invalidate_tag target the same line in one cycle, the fill SHALL win.
REQ-019 The request outputs SHALL come only from registered state; the request SHALL never drop between REQ entry and FILL.

Reset
REQ-020 On reset, all lines SHALL be INVALID with tag 000, FSM = IDLE, and counter = 0.
REQ-021 On reset, stall, read_miss, write_miss, search_found, fill_done and miss_count SHALL be 0, write_miss_state SHALL be 10, and tag_in SHALL be 0.
REQ-022 Reset asserted mid-miss SHALL abort the miss with no directory update.

Configuration
REQ-023 With COH_MISS_CNT_EN defined, miss_count SHALL increment by one on each REQ entry and saturate at 255.
REQ-024 Without COH_MISS_CNT_EN, miss_count SHALL be tied to 0 and no counter flops shall exist.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Reset, then cpu_rd addr 5'h0D, grant on cycle 2: read_miss, tag_in = 0D; fill_done at cycle 6; line 1 = tag 3, S.
  - Same read repeated: stall stays 0, no read_miss.
  - Write to 0D while line is S: write_miss with state 01; after fill, line = M.
  - search tag_out = 0D while line is M: search_found = 1 next cycle, line -> S.
  - Write miss to 0E in REQ, grant withheld, invalidate_tag on 0E: write_miss held, state -> 10.
  - Grant dropped in XFER cycle 2: FSM returns to REQ, counter = 0.
  - 300 misses with COH_MISS_CNT_EN: miss_count = 255.
